// File: rtl/mma_dot_stream.sv
// Streaming N-lane dot-product engine: multiplies lane-wise over cfg_beats beats and
// accumulates into a saturating ACC_WIDTH accumulator, result held on a valid/ready port.
module mma_dot_stream #(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 32,
  parameter int MAX_BEATS = 16,
  parameter int BW        = $clog2(MAX_BEATS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   cfg_signed,
  input  logic [BW-1:0]          cfg_beats,
  output logic                   cfg_err,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*WIDTH-1:0]     in_a,
  input  logic [N*WIDTH-1:0]     in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_data,
  output logic                   out_ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = PW + $clog2(N);
  // Wide enough for acc plus a full beat sum even when SW exceeds ACC_WIDTH.
  localparam int EW = ((ACC_WIDTH > SW) ? ACC_WIDTH : SW) + 2;
  localparam logic [BW-1:0] MAXB = BW'(MAX_BEATS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t                 state_q;
  logic                   signed_q;
  logic [BW-1:0]          beats_q;
  logic [BW-1:0]          cnt_q;
  logic                   in_ready_q;
  logic                   cfg_err_q;
  logic [PW-1:0]          prod_q [N];
  logic [PW-1:0]          prod_d [N];
  logic                   pv_q;
  logic                   plast_q;
  logic                   alast_q;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [ACC_WIDTH-1:0]   acc_d;
  logic                   ovf_q;
  logic                   out_valid_q;
  logic [ACC_WIDTH-1:0]   out_data_q;
  logic                   out_ovf_q;

  logic                   hs;
  logic                   last_beat;
  logic                   cfg_ok;
  logic                   sat;
  logic [PW-1:0]          ax;
  logic [PW-1:0]          bx;
  logic signed [EW-1:0]   sum_x;
  logic signed [EW-1:0]   acc_x;
  logic signed [EW-1:0]   tot;
  logic signed [EW-1:0]   max_v;
  logic signed [EW-1:0]   min_v;

  assign hs        = (state_q == RUN) && in_valid && in_ready_q;
  assign last_beat = (cnt_q == beats_q - 1'b1);
  assign cfg_ok    = (cfg_beats != '0) && (cfg_beats <= MAXB);

  // Operands extended to full product width; the low PW bits of the product are exact.
  always_comb begin
    ax     = '0;
    bx     = '0;
    prod_d = '{default: '0};
    for (int unsigned j = 0; j < N; j++) begin
      ax = {{WIDTH{signed_q & in_a[j*WIDTH+WIDTH-1]}}, in_a[j*WIDTH +: WIDTH]};
      bx = {{WIDTH{signed_q & in_b[j*WIDTH+WIDTH-1]}}, in_b[j*WIDTH +: WIDTH]};
      prod_d[j] = ax * bx;
    end
  end

  always_comb begin
    sum_x = '0;
    for (int unsigned j = 0; j < N; j++) begin
      sum_x = sum_x + {{(EW-PW){signed_q & prod_q[j][PW-1]}}, prod_q[j]};
    end
    acc_x = {{(EW-ACC_WIDTH){signed_q & acc_q[ACC_WIDTH-1]}}, acc_q};
    tot   = sum_x + acc_x;
    max_v = '0;
    min_v = '0;
    if (signed_q) begin
      max_v[ACC_WIDTH-2:0] = '1;
      min_v                = '1;
      min_v[ACC_WIDTH-2:0] = '0;
    end else begin
      max_v[ACC_WIDTH-1:0] = '1;
    end
    sat   = 1'b0;
    acc_d = tot[ACC_WIDTH-1:0];
    if (tot > max_v) begin
      acc_d = max_v[ACC_WIDTH-1:0];
      sat   = 1'b1;
    end else if (tot < min_v) begin
      acc_d = min_v[ACC_WIDTH-1:0];
      sat   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      signed_q    <= 1'b0;
      beats_q     <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      prod_q      <= '{default: '0};
      pv_q        <= 1'b0;
      plast_q     <= 1'b0;
      alast_q     <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      pv_q      <= hs;
      plast_q   <= hs && last_beat;
      alast_q   <= pv_q && plast_q;
      if (hs) prod_q <= prod_d;
      if (pv_q) begin
        acc_q <= acc_d;
        if (sat) ovf_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              signed_q   <= cfg_signed;
              beats_q    <= cfg_beats;
              cnt_q      <= '0;
              acc_q      <= '0;
              ovf_q      <= 1'b0;
              in_ready_q <= 1'b1;
              state_q    <= RUN;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (hs) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_beat) begin
              in_ready_q <= 1'b0;
              state_q    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (alast_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= acc_q;
            out_ovf_q   <= ovf_q;
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_err   = cfg_err_q;
  assign busy      = (state_q != IDLE);
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mma_dot_stream.sv
// Scoreboard bench for mma_dot_stream: 32-bit and 16-bit accumulator instances share stimulus.
module tb_mma_dot_stream;
  localparam int N = 4;
  localparam int W = 8;
  localparam int MAXB = 16;
  localparam int BW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, start, cfg_signed, in_valid, out_ready;
  logic [BW-1:0]  cfg_beats;
  logic [N*W-1:0] in_a, in_b;
  logic           cfg_err, busy, in_ready, out_valid, out_ovf;
  logic [31:0]    out_data;
  logic           cfg_err16, busy16, in_ready16, out_valid16, out_ovf16;
  logic [15:0]    out_data16;

  mma_dot_stream #(.N(N), .WIDTH(W), .ACC_WIDTH(32), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_signed(cfg_signed), .cfg_beats(cfg_beats),
    .cfg_err(cfg_err), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf));

  mma_dot_stream #(.N(N), .WIDTH(W), .ACC_WIDTH(16), .MAX_BEATS(MAXB)) dut16 (
    .clk(clk), .rst(rst), .start(start), .cfg_signed(cfg_signed), .cfg_beats(cfg_beats),
    .cfg_err(cfg_err16), .busy(busy16), .in_valid(in_valid), .in_ready(in_ready16),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid16), .out_ready(out_ready),
    .out_data(out_data16), .out_ovf(out_ovf16));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  longint      q32d[$], q16d[$];
  bit          q32o[$], q16o[$];
  logic [31:0] op_a [16];
  logic [31:0] op_b [16];

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (q32d.size() == 0) check("out32_unexpected", 1, 0);
      else begin
        check("out32_data", out_data, q32d.pop_front());
        check("out32_ovf", out_ovf, q32o.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid16 && out_ready) begin
      if (q16d.size() == 0) check("out16_unexpected", 1, 0);
      else begin
        check("out16_data", out_data16, q16d.pop_front());
        check("out16_ovf", out_ovf16, q16o.pop_front());
      end
    end
  end

  function automatic longint lane(input logic [7:0] v, input bit sg);
    return sg ? longint'($signed(v)) : longint'(v);
  endfunction

  function automatic longint sat_add(input longint acc, input longint s, input bit sg,
                                     input int aw, output bit cl);
    longint mx, mn, t;
    if (sg) begin
      mx = (longint'(1) <<< (aw - 1)) - 1;
      mn = -(longint'(1) <<< (aw - 1));
    end else begin
      mx = (longint'(1) <<< aw) - 1;
      mn = 0;
    end
    t  = acc + s;
    cl = 1'b0;
    if (t > mx) begin t = mx; cl = 1'b1; end
    else if (t < mn) begin t = mn; cl = 1'b1; end
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (!busy) done = 1'b1;
      else tick();
    end
    if (!done) check("idle_timeout", 0, 1);
  endtask

  task automatic run_op(input bit sg, input int nb, input bit gaps, input bit poke, input bit lat);
    longint a32 = 0, a16 = 0, s;
    bit     o32 = 1'b0, o16 = 1'b0, cl;
    int     i = 0, c = 0;
    bit     hs;
    for (int b = 0; b < nb; b++) begin
      s = 0;
      for (int j = 0; j < N; j++)
        s += lane(op_a[b][j*W +: W], sg) * lane(op_b[b][j*W +: W], sg);
      a32 = sat_add(a32, s, sg, 32, cl); o32 |= cl;
      a16 = sat_add(a16, s, sg, 16, cl); o16 |= cl;
    end
    start = 1'b1; cfg_signed = sg; cfg_beats = BW'(nb);
    tick();
    start = 1'b0;
    while (i < nb && c < 400) begin
      in_valid = gaps ? (c % 2 == 0) : 1'b1;
      in_a = op_a[i];
      in_b = op_b[i];
      if (poke && c == 1) begin start = 1'b1; cfg_beats = '0; end
      hs = in_valid && in_ready;
      tick();
      if (poke && c == 1) begin
        start = 1'b0;
        check("start_in_run_err", cfg_err, 0);
        check("start_in_run_busy", busy, 1);
      end
      if (hs) i++;
      c++;
    end
    in_valid = 1'b0;
    if (i < nb) check("beat_timeout", 0, 1);
    else begin
      q32d.push_back(a32 & 64'hFFFF_FFFF); q32o.push_back(o32);
      q16d.push_back(a16 & 64'hFFFF);      q16o.push_back(o16);
    end
    if (lat) begin
      check("lat_e0", out_valid, 0);
      tick(); check("lat_e1", out_valid, 0);
      tick(); check("lat_e2", out_valid, 1); check("lat_busy", busy, 1);
      tick(); check("busy_after_out", busy, 0);
    end
  endtask

  initial begin
    logic [31:0] d_hold;
    logic        o_hold;
    bit          seen;
    rst = 1'b1; start = 1'b0; cfg_signed = 1'b0; cfg_beats = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    tick(); tick();
    check("rst_cfg_err", cfg_err, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    rst = 1'b0;
    tick();

    // 1: unsigned single beat, latency
    op_a[0] = {8'd4, 8'd3, 8'd2, 8'd1};
    op_b[0] = {8'd8, 8'd7, 8'd6, 8'd5};
    run_op(1'b0, 1, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // 2: all 0xFF x 0x02, two beats, signed then unsigned
    for (int b = 0; b < 2; b++) begin op_a[b] = 32'hFFFF_FFFF; op_b[b] = 32'h0202_0202; end
    run_op(1'b1, 2, 1'b0, 1'b0, 1'b0); wait_idle();
    run_op(1'b0, 2, 1'b0, 1'b0, 1'b0); wait_idle();

    // 3: input gaps and output backpressure
    for (int b = 0; b < 3; b++) begin op_a[b] = $urandom; op_b[b] = $urandom; end
    out_ready = 1'b0;
    run_op(1'b1, 3, 1'b1, 1'b0, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (out_valid) seen = 1'b1; else tick();
    end
    check("stall_valid", out_valid, 1);
    d_hold = out_data; o_hold = out_ovf;
    repeat (5) begin
      tick();
      check("stall_data", out_data, d_hold);
      check("stall_ovf", out_ovf, o_hold);
      check("stall_in_ready", in_ready, 0);
      check("stall_valid_held", out_valid, 1);
    end
    out_ready = 1'b1;
    wait_idle();

    // 4: saturation on the 16-bit instance, then sticky clear
    op_a[0] = 32'hFFFF_FFFF; op_b[0] = 32'hFFFF_FFFF;
    run_op(1'b0, 1, 1'b0, 1'b0, 1'b0); wait_idle();
    op_a[0] = {8'd4, 8'd3, 8'd2, 8'd1}; op_b[0] = {8'd8, 8'd7, 8'd6, 8'd5};
    run_op(1'b0, 1, 1'b0, 1'b0, 1'b0); wait_idle();

    // 5: illegal cfg_beats, start during RUN
    start = 1'b1; cfg_beats = '0; tick(); start = 1'b0;
    check("err0_pulse", cfg_err, 1); check("err0_busy", busy, 0);
    tick(); check("err0_clear", cfg_err, 0);
    start = 1'b1; cfg_beats = BW'(MAXB + 1); tick(); start = 1'b0;
    check("err17_pulse", cfg_err, 1); check("err17_busy", busy, 0);
    tick(); check("err17_clear", cfg_err, 0);
    for (int b = 0; b < 3; b++) begin op_a[b] = $urandom; op_b[b] = $urandom; end
    run_op(1'b1, 3, 1'b0, 1'b1, 1'b0); wait_idle();

    // 6: reset mid-operation
    start = 1'b1; cfg_signed = 1'b0; cfg_beats = 5'd3; tick(); start = 1'b0;
    in_valid = 1'b1; in_a = 32'h0505_0505; in_b = 32'h0303_0303; tick();
    in_valid = 1'b0; rst = 1'b1; tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    rst = 1'b0;
    repeat (4) tick();
    op_a[0] = 32'h0101_0101; op_b[0] = 32'h0202_0202;
    run_op(1'b0, 1, 1'b0, 1'b0, 1'b0); wait_idle();

    // random operations, first at MAX_BEATS
    for (int r = 0; r < 5; r++) begin
      int nb;
      nb = (r == 0) ? MAXB : int'($urandom_range(1, MAXB));
      for (int b = 0; b < nb; b++) begin op_a[b] = $urandom; op_b[b] = $urandom; end
      run_op(1'($urandom % 2), nb, 1'($urandom % 2), 1'b0, 1'b0);
      wait_idle();
    end

    repeat (4) tick();
    check("q32_drained", q32d.size(), 0);
    check("q16_drained", q16d.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end
endmodule
